// File: rtl/apb_can_msg_fifo_slave_if.sv
// APB4 completer-side bus bundle between the AXI-lite-to-APB bridge and the CAN message FIFO.
interface apb_can_msg_fifo_slave_if;
  logic [31:0] s_apb_paddr;
  logic        s_apb_psel;
  logic        s_apb_penable;
  logic        s_apb_pwrite;
  logic [31:0] s_apb_pwdata;
  logic [3:0]  s_apb_pstrb;
  logic [2:0]  s_apb_pprot;
  logic [31:0] s_apb_prdata;
  logic        s_apb_pready;
  logic        s_apb_pslverr;

  modport master (
    output s_apb_paddr, s_apb_psel, s_apb_penable, s_apb_pwrite,
           s_apb_pwdata, s_apb_pstrb, s_apb_pprot,
    input  s_apb_prdata, s_apb_pready, s_apb_pslverr
  );

  modport slave (
    input  s_apb_paddr, s_apb_psel, s_apb_penable, s_apb_pwrite,
           s_apb_pwdata, s_apb_pstrb, s_apb_pprot,
    output s_apb_prdata, s_apb_pready, s_apb_pslverr
  );
endinterface

// File: rtl/apb_can_msg_fifo_slave.sv
// APB4 completer buffering CAN message words in a FIFO and streaming them to the CAN TX datapath.
module apb_can_msg_fifo_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          WAIT_STATES = 1
) (
  input  logic                          aclk,
  input  logic                          arstn,
  apb_can_msg_fifo_slave_if.slave       apb,
  output logic                          m_valid,
  output logic [31:0]                   m_data,
  input  logic                          m_ready,
  output logic                          irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]    state_reg;
  logic [2:0]    wait_cnt_reg;
  logic          en_reg;
  logic          ovf_reg;
  logic [31:0]   scratch_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic [31:0]   mem [FIFO_DEPTH];

  logic [11:0] offset;
  logic        setup, access, pready, err, commit, wr_ok;
  logic        sel_ctrl, sel_status, sel_tx, sel_scratch, addr_ok;
  logic        fifo_empty, fifo_full, pop, push, push_req, push_blocked;
  logic        flush, ovf_clr, ovf_set;
  logic [31:0] rdata;
  logic        unused_ok;

  assign unused_ok = ^{apb.s_apb_pprot, apb.s_apb_paddr[31:12]};

  // Bridge already decoded the segment; only the low 4 KiB offset matters here.
  assign offset      = apb.s_apb_paddr[11:0] - BASE_ADDR[11:0];
  assign addr_ok     = (offset[1:0] == 2'b00) && (offset <= 12'h00C);
  assign sel_ctrl    = (offset == 12'h000);
  assign sel_status  = (offset == 12'h004);
  assign sel_tx      = (offset == 12'h008);
  assign sel_scratch = (offset == 12'h00C);

  assign setup  = apb.s_apb_psel & ~apb.s_apb_penable;
  assign access = apb.s_apb_psel & apb.s_apb_penable;
  assign pready = (state_reg == S_ACCESS) && access && (wait_cnt_reg == 3'd0);
  assign commit = pready;

  assign fifo_empty = (level_reg == '0);
  assign fifo_full  = (level_reg == LW'(FIFO_DEPTH));
  assign m_valid    = en_reg & ~fifo_empty;
  assign m_data     = mem[rd_ptr_reg];
  assign pop        = m_valid & m_ready;
  assign irq        = ovf_reg;

  // A push into a full FIFO is fine when the consumer frees a slot on the same edge.
  assign push_req     = apb.s_apb_pwrite & sel_tx;
  assign push_blocked = fifo_full & ~pop;
  assign err = ~addr_ok
             | (apb.s_apb_pwrite & sel_status)
             | (push_req & (push_blocked | ~en_reg));

  assign wr_ok   = commit & apb.s_apb_pwrite & ~err;
  assign push    = wr_ok & sel_tx;
  assign flush   = wr_ok & sel_ctrl & apb.s_apb_pwdata[1];
  assign ovf_clr = wr_ok & sel_ctrl & apb.s_apb_pwdata[2];
  assign ovf_set = commit & push_req & push_blocked;

  always_comb begin
    rdata = 32'h0;
    if (sel_ctrl)    rdata = {31'h0, en_reg};
    if (sel_status)  rdata = {21'h0, ovf_reg, fifo_full, fifo_empty, 1'b0, 7'(level_reg)};
    if (sel_scratch) rdata = scratch_reg;
  end

  assign apb.s_apb_pready  = pready;
  assign apb.s_apb_pslverr = pready & err;
  assign apb.s_apb_prdata  = (pready & ~apb.s_apb_pwrite & ~err) ? rdata : 32'h0;

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= 3'd0;
    end else begin
      case (state_reg)
        S_IDLE: if (setup) begin
          state_reg    <= S_ACCESS;
          wait_cnt_reg <= 3'(WAIT_STATES);
        end
        S_ACCESS: begin
          if (!apb.s_apb_psel) begin
            state_reg <= S_IDLE;
          end else if (apb.s_apb_penable) begin
            if (wait_cnt_reg == 3'd0) state_reg <= S_DONE;
            else                      wait_cnt_reg <= wait_cnt_reg - 3'd1;
          end
        end
        S_DONE: begin
          if (setup) begin
            state_reg    <= S_ACCESS;
            wait_cnt_reg <= 3'(WAIT_STATES);
          end else begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      en_reg  <= 1'b0;
      ovf_reg <= 1'b0;
    end else begin
      if (wr_ok && sel_ctrl) en_reg <= apb.s_apb_pwdata[0];
      if (ovf_set)           ovf_reg <= 1'b1;
      else if (ovf_clr)      ovf_reg <= 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_scratch
      always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) scratch_reg[gi*8 +: 8] <= 8'h0;
        else if (wr_ok && sel_scratch && apb.s_apb_pstrb[gi])
          scratch_reg[gi*8 +: 8] <= apb.s_apb_pwdata[gi*8 +: 8];
      end
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
      always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) mem[gi] <= 32'h0;
        else if (push && (wr_ptr_reg == AW'(gi))) mem[gi] <= apb.s_apb_pwdata;
      end
    end
  endgenerate

  // Flush wins over a same-cycle pop; storage is deliberately left intact.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      level_reg <= level_reg + LW'(push) - LW'(pop);
    end
  end
endmodule
